// File: rtl/unified_mem_arbiter.sv
// Shares one single-port unified memory between the fetch port and the data port.
// Data-first arbitration with a fetch anti-starvation limit; IDLE -> ACCESS -> RESP sequencing.
module unified_mem_arbiter #(
  parameter int WAIT_STATES    = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_streak;
  logic [CW-1:0]   r_wait;
  logic            r_owner;
  logic            r_en;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_if_rdata;
  logic [31:0]     r_dm_rdata;
  logic            r_if_ready;
  logic            r_dm_ready;
  logic            r_busy;

  logic            w_any_req;
  logic            w_grant_data;

  // Handshake: a requester raises req and holds it (with stable address/data) until its
  // ready pulse; ready is high for exactly one cycle, in the RESP state of its access.
  assign w_any_req    = if_req | dm_req;
  assign w_grant_data = dm_req & ~(if_req & (r_streak == SW'(MAX_DATA_BURST)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_streak   <= '0;
      r_wait     <= '0;
      r_owner    <= 1'b0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_ACCESS;
            r_busy  <= 1'b1;
            r_en    <= 1'b1;
            r_owner <= w_grant_data;
            r_we    <= w_grant_data & dm_we;
            r_addr  <= w_grant_data ? dm_addr : if_addr;
            r_wdata <= w_grant_data ? dm_wdata : '0;
            r_wait  <= CW'(WAIT_STATES);
            // Streak only grows while a fetch is actually being held off.
            if (w_grant_data && if_req) begin
              if (r_streak != SW'(MAX_DATA_BURST)) r_streak <= r_streak + 1'b1;
            end else begin
              r_streak <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (r_wait == '0) begin
            if (!r_we) begin
              if (r_owner) r_dm_rdata <= mem_rdata;
              else         r_if_rdata <= mem_rdata;
            end
            r_en       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_ready <= ~r_owner;
            r_dm_ready <= r_owner;
            r_state    <= S_RESP;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_RESP: begin
          r_if_ready <= 1'b0;
          r_dm_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_ready  = r_if_ready;
  assign dm_rdata  = r_dm_rdata;
  assign dm_ready  = r_dm_ready;
  assign mem_en    = r_en;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule
